// File: rtl/cpu_pkg.sv
// Shared definitions for the processor control path: select codes, opcodes,
// ALU operations, sequencer states and the EXEC-phase control bundle.
package cpu_pkg;

    // Register/bus select codes shared by the write-enable decoder and bus mux
    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_R1   = 4'd1;
    localparam logic [3:0] SEL_R2   = 4'd2;
    localparam logic [3:0] SEL_R3   = 4'd3;
    localparam logic [3:0] SEL_R4   = 4'd4;
    localparam logic [3:0] SEL_R5   = 4'd5;
    localparam logic [3:0] SEL_AR   = 4'd6;
    localparam logic [3:0] SEL_AC   = 4'd7;
    localparam logic [3:0] SEL_IR   = 4'd8;
    localparam logic [3:0] SEL_PC   = 4'd9;
    localparam logic [3:0] SEL_MEM  = 4'd10;
    localparam logic [3:0] SEL_ALU  = 4'd11;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_MVAR  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_MVACR = 4'h6;
    localparam logic [3:0] OP_MVRAC = 4'h7;
    localparam logic [3:0] OP_INCAC = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JPNZ  = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_INC  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F_AR,
        ST_F_MEM,
        ST_DECODE,
        ST_EXEC,
        ST_EXEC_MEM,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [3:0] wr_sel;
        logic [3:0] rd_sel;
        logic [1:0] alu_op;
        logic       illegal;
    } exec_ctl_t;

    // Only R1..R5 exist; codes 0, 6 and 7 in the register field are reserved
    function automatic logic reg_field_ok(input logic [2:0] n);
        return (n >= 3'd1) && (n <= 3'd5);
    endfunction

    function automatic logic [3:0] reg_sel(input logic [2:0] n);
        return {1'b0, n};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational EXEC-phase decode: (opcode, register field, zero flag) to the
// bus/write selects, ALU operation and illegal-instruction flag.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] reg_field,
    input  logic       z_flag,
    output exec_ctl_t  ctl
);

    logic reg_ok;

    assign reg_ok = reg_field_ok(reg_field);

    always_comb begin
        ctl = '0;
        case (opcode)
            OP_NOP, OP_LDAC, OP_STAC, OP_HALT: ctl = '0;
            OP_MVAR: begin
                ctl.rd_sel = SEL_AC;
                ctl.wr_sel = SEL_AR;
            end
            OP_ADD, OP_SUB: begin
                if (reg_ok) begin
                    ctl.rd_sel = reg_sel(reg_field);
                    ctl.alu_op = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                    ctl.wr_sel = SEL_AC;
                end else begin
                    ctl.illegal = 1'b1;
                end
            end
            OP_MVACR: begin
                if (reg_ok) begin
                    ctl.rd_sel = SEL_AC;
                    ctl.wr_sel = reg_sel(reg_field);
                end else begin
                    ctl.illegal = 1'b1;
                end
            end
            OP_MVRAC: begin
                if (reg_ok) begin
                    ctl.rd_sel = reg_sel(reg_field);
                    ctl.wr_sel = SEL_AC;
                end else begin
                    ctl.illegal = 1'b1;
                end
            end
            OP_INCAC: begin
                ctl.alu_op = ALU_INC;
                ctl.wr_sel = SEL_AC;
            end
            OP_JMP: begin
                ctl.rd_sel = SEL_AC;
                ctl.wr_sel = SEL_PC;
            end
            OP_JPNZ: begin
                // A taken branch is an ordinary JMP; not-taken writes nothing
                if (!z_flag) begin
                    ctl.rd_sel = SEL_AC;
                    ctl.wr_sel = SEL_PC;
                end
            end
            default: ctl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer; all outputs decode combinationally
// from the registered state, the IR contents, z_flag and mem_ready.
module control_unit
    import cpu_pkg::*;
#(
    parameter int IR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IR_W-1:0] ir,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic [3:0]      wr_sel,
    output logic [3:0]      rd_sel,
    output logic [1:0]      alu_op,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            pc_inc,
    output logic            halted,
    output logic            illegal
);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] opcode;
    logic [2:0] reg_field;
    exec_ctl_t  exec_ctl;
    logic       ir_unused;

    assign opcode    = ir[7:4];
    assign reg_field = ir[2:0];
    assign ir_unused = ir[3];

    generate
        if (IR_W > 8) begin : g_wide_ir
            logic hi_unused;
            assign hi_unused = ^ir[IR_W-1:8];
        end
    endgenerate

    instr_decode u_instr_decode (
        .opcode    (opcode),
        .reg_field (reg_field),
        .z_flag    (z_flag),
        .ctl       (exec_ctl)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_sel     = SEL_NONE;
        rd_sel     = SEL_NONE;
        alu_op     = ALU_PASS;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        pc_inc     = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_F_AR;
                end
            end
            ST_F_AR: begin
                rd_sel     = SEL_PC;
                wr_sel     = SEL_AR;
                state_next = ST_F_MEM;
            end
            ST_F_MEM: begin
                // Read strobe is held; IR is only loaded in the ready cycle
                mem_rd = 1'b1;
                if (mem_ready) begin
                    rd_sel     = SEL_MEM;
                    wr_sel     = SEL_IR;
                    pc_inc     = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LDAC, OP_STAC: state_next = ST_EXEC_MEM;
                    OP_HALT:          state_next = ST_HALT;
                    default:          state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                wr_sel     = exec_ctl.wr_sel;
                rd_sel     = exec_ctl.rd_sel;
                alu_op     = exec_ctl.alu_op;
                illegal    = exec_ctl.illegal;
                state_next = ST_F_AR;
            end
            ST_EXEC_MEM: begin
                mem_rd = (opcode == OP_LDAC);
                mem_wr = (opcode == OP_STAC);
                if (mem_ready) begin
                    if (opcode == OP_LDAC) begin
                        rd_sel = SEL_MEM;
                        wr_sel = SEL_AC;
                    end
                    state_next = ST_F_AR;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: the driver pushes the expected
// per-cycle output set, the monitor pops and compares on each falling edge.
module tb_control_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [3:0] wr;
        logic [3:0] rd;
        logic [1:0] alu;
        logic       mrd;
        logic       mwr;
        logic       pci;
        logic       hlt;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       z_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] wr_sel;
    logic [3:0] rd_sel;
    logic [1:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_inc;
    logic       halted;
    logic       illegal;

    control_unit #(.IR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ir        (ir),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .wr_sel    (wr_sel),
        .rd_sel    (rd_sel),
        .alu_op    (alu_op),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .pc_inc    (pc_inc),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    done = 1'b0;

    function automatic exp_t mk(input int wr, input int rd, input int alu, input bit mrd,
                                input bit mwr, input bit pci, input bit hlt, input bit ill);
        exp_t e;
        e.wr  = 4'(wr);
        e.rd  = 4'(rd);
        e.alu = 2'(alu);
        e.mrd = mrd;
        e.mwr = mwr;
        e.pci = pci;
        e.hlt = hlt;
        e.ill = ill;
        return e;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("wr=%0d rd=%0d alu=%0d mem_rd=%0b mem_wr=%0b pc_inc=%0b halted=%0b illegal=%0b",
                         v.wr, v.rd, v.alu, v.mrd, v.mwr, v.pci, v.hlt, v.ill);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference behaviour of one EXEC cycle, straight from the instruction table
    function automatic exp_t exec_model(input logic [7:0] iv, input logic zf);
        int   op = int'(iv[7:4]);
        int   n  = int'(iv[2:0]);
        bit   ok = (n >= 1) && (n <= 5);
        exp_t e  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        case (op)
            0:    e = mk(0, 0, 0, 0, 0, 0, 0, 0);
            3:    e = mk(6, 7, 0, 0, 0, 0, 0, 0);
            4, 5: e = ok ? mk(7, n, op - 3, 0, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1);
            6:    e = ok ? mk(n, 7, 0, 0, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1);
            7:    e = ok ? mk(7, n, 0, 0, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 1);
            8:    e = mk(7, 0, 3, 0, 0, 0, 0, 0);
            9:    e = mk(9, 7, 0, 0, 0, 0, 0, 0);
            10:   e = zf ? mk(0, 0, 0, 0, 0, 0, 0, 0) : mk(9, 7, 0, 0, 0, 0, 0, 0);
            default: e = mk(0, 0, 0, 0, 0, 0, 0, 1);
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue the expectation
    task automatic step(input exp_t e, input string nm, input logic [7:0] iv, input logic mr,
                        input logic st, input logic zf, input logic r);
        @(posedge clk);
        #1;
        ir        = iv;
        mem_ready = mr;
        start     = st;
        z_flag    = zf;
        rst       = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc++;
    endtask

    task automatic fetch_decode(input logic [7:0] iv, input int wf);
        step(mk(6, 9, 0, 0, 0, 0, 0, 0), "f_ar", iv, rb(), rb(), rb(), 1'b0);
        repeat (wf) step(mk(0, 0, 0, 1, 0, 0, 0, 0), "f_mem_wait", iv, 1'b0, rb(), rb(), 1'b0);
        step(mk(8, 10, 0, 1, 0, 1, 0, 0), "f_mem_ready", iv, 1'b1, rb(), rb(), 1'b0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0), "decode", iv, rb(), rb(), rb(), 1'b0);
    endtask

    task automatic run_instr(input logic [7:0] iv, input int wf, input int we, input logic zx);
        int op = int'(iv[7:4]);
        int c0 = cyc;
        fetch_decode(iv, wf);
        if (op == 1) begin
            repeat (we) step(mk(0, 0, 0, 1, 0, 0, 0, 0), "ldac_wait", iv, 1'b0, rb(), rb(), 1'b0);
            step(mk(7, 10, 0, 1, 0, 0, 0, 0), "ldac_ready", iv, 1'b1, rb(), rb(), 1'b0);
        end else if (op == 2) begin
            repeat (we) step(mk(0, 0, 0, 0, 1, 0, 0, 0), "stac_wait", iv, 1'b0, rb(), rb(), 1'b0);
            step(mk(0, 0, 0, 0, 1, 0, 0, 0), "stac_ready", iv, 1'b1, rb(), rb(), 1'b0);
        end else begin
            step(exec_model(iv, zx), "exec", iv, rb(), rb(), zx, 1'b0);
        end
        $display("instr ir=0x%02h z=%0b fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 iv, zx, wf, we, cyc - c0);
    endtask

    exp_t  mon_exp;
    exp_t  mon_act;
    string mon_name;

    initial begin : monitor
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = {wr_sel, rd_sel, alu_op, mem_rd, mem_wr, pc_inc, halted, illegal};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s @%0t: got %s, expected %s",
                             mon_name, $time, fmt(mon_act), fmt(mon_exp));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : driver
        logic [7:0] iv;
        exp_t       zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held (start ignored), release, idle without start, then start
        step(zero, "reset", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(zero, "reset", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(zero, "after_release", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(zero, "idle", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Directed instructions
        run_instr(8'h00, 0, 0, 1'b0);
        run_instr(8'h43, 0, 0, 1'b1);
        run_instr(8'h63, 1, 0, 1'b0);
        run_instr(8'h10, 0, 3, 1'b0);
        run_instr(8'hA0, 0, 0, 1'b0);
        run_instr(8'hA0, 2, 0, 1'b1);
        run_instr(8'h46, 0, 0, 1'b0);
        run_instr(8'hC0, 0, 0, 1'b0);
        run_instr(8'h20, 0, 2, 1'b0);
        run_instr(8'h57, 0, 0, 1'b0);
        run_instr(8'h75, 0, 0, 1'b1);

        // Random instruction stream (HALT excluded; it ends the stream)
        for (int i = 0; i < 150; i++) begin
            iv = 8'($urandom_range(0, 255));
            if (iv[7:4] == 4'hF) iv[7:4] = 4'h0;
            run_instr(iv, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end

        // Reset asserted while STAC waits for memory
        fetch_decode(8'h20, 0);
        step(mk(0, 0, 0, 0, 1, 0, 0, 0), "stac_wait", 8'h20, 1'b0, 1'b0, rb(), 1'b0);
        step(mk(0, 0, 0, 0, 1, 0, 0, 0), "stac_wait", 8'h20, 1'b0, 1'b0, rb(), 1'b0);
        step(zero, "rst_in_stac", 8'h20, 1'b1, 1'b0, rb(), 1'b1);
        step(zero, "after_release", 8'h20, 1'b1, 1'b0, rb(), 1'b0);
        step(zero, "idle", 8'h20, 1'b1, 1'b1, rb(), 1'b0);
        $display("instr ir=0x20 reset during wait");

        for (int i = 0; i < 20; i++) begin
            iv = 8'($urandom_range(0, 255));
            if (iv[7:4] == 4'hF) iv[7:4] = 4'h8;
            run_instr(iv, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        // HALT persists through ten start pulses and random mem_ready
        fetch_decode(8'hF0, 1);
        for (int i = 0; i < 20; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 0), "halt", 8'hF0, rb(), 1'((i % 2) == 0), rb(), 1'b0);
        end
        $display("instr ir=0xF0 halted with 10 start pulses");

        step(zero, "final_reset", 8'hF0, rb(), 1'b1, 1'b0, 1'b1);
        step(zero, "final_idle", 8'h00, rb(), 1'b0, 1'b0, 1'b0);
        done = 1'b1;
    end

endmodule
